// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of in_instr captured into a
// main register (drives outputs) backed by a one-entry skid register.
// Optional performance counters are enabled with `define DECODE_PERF_CNT_EN.
module decode_stage #(
  parameter int unsigned XLEN  = 32
`ifdef DECODE_PERF_CNT_EN
  ,parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [3:0]      inst_type,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
`ifdef DECODE_PERF_CNT_EN
  ,output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] IT_LOAD  = 4'd1;
  localparam logic [3:0] IT_STORE = 4'd2;
  localparam logic [3:0] IT_RALU  = 4'd3;
  localparam logic [3:0] IT_IALU  = 4'd4;
  localparam logic [3:0] IT_BR    = 4'd5;
  localparam logic [3:0] IT_LUI   = 4'd6;
  localparam logic [3:0] IT_AUIPC = 4'd7;
  localparam logic [3:0] IT_JAL   = 4'd8;
  localparam logic [3:0] IT_JALR  = 4'd9;
  localparam logic [3:0] IT_SYS   = 4'd10;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [3:0]      inst_type;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, dec;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire, bad;

  logic [6:0]      f_op;
  logic [2:0]      f_f3;
  logic [6:0]      f_f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f_op  = in_instr[6:0];
  assign f_f3  = in_instr[14:12];
  assign f_f7  = in_instr[31:25];
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Decode the incoming instruction word into an entry
  always_comb begin
    dec          = '0;
    bad          = 1'b0;
    dec.pc       = in_pc;
    dec.opcode   = f_op;
    dec.imm_type = IMM_NONE;
    case (f_op)
      OP_LOAD: begin
        dec.inst_type = IT_LOAD;  dec.imm_type = IMM_I; dec.imm = imm_i;
        dec.rd = in_instr[11:7];  dec.rs1 = in_instr[19:15]; dec.func3 = f_f3;
        bad = (f_f3 == 3'b011) || (f_f3 == 3'b110) || (f_f3 == 3'b111);
      end
      OP_STORE: begin
        dec.inst_type = IT_STORE; dec.imm_type = IMM_S; dec.imm = imm_s;
        dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.func3 = f_f3;
        bad = (f_f3 > 3'b010);
      end
      OP_REG: begin
        dec.inst_type = IT_RALU;
        dec.rd = in_instr[11:7];  dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20];
        dec.func3 = f_f3;         dec.func7 = f_f7;
        bad = ((f_f7 != F7_ZERO) && (f_f7 != F7_ALT)) ||
              ((f_f7 == F7_ALT) && (f_f3 != 3'b000) && (f_f3 != 3'b101));
      end
      OP_IMM: begin
        dec.inst_type = IT_IALU;  dec.imm_type = IMM_I; dec.imm = imm_i;
        dec.rd = in_instr[11:7];  dec.rs1 = in_instr[19:15]; dec.func3 = f_f3;
        if (f_f3 == 3'b001) begin
          dec.func7 = f_f7;
          bad = (f_f7 != F7_ZERO);
        end else if (f_f3 == 3'b101) begin
          dec.func7 = f_f7;
          bad = (f_f7 != F7_ZERO) && (f_f7 != F7_ALT);
        end
      end
      OP_BRANCH: begin
        dec.inst_type = IT_BR;    dec.imm_type = IMM_B; dec.imm = imm_b;
        dec.rs1 = in_instr[19:15]; dec.rs2 = in_instr[24:20]; dec.func3 = f_f3;
        bad = (f_f3 == 3'b010) || (f_f3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        dec.inst_type = (f_op == OP_LUI) ? IT_LUI : IT_AUIPC;
        dec.imm_type  = IMM_U;    dec.imm = imm_u; dec.rd = in_instr[11:7];
      end
      OP_JAL: begin
        dec.inst_type = IT_JAL;   dec.imm_type = IMM_J; dec.imm = imm_j;
        dec.rd = in_instr[11:7];
      end
      OP_JALR: begin
        dec.inst_type = IT_JALR;  dec.imm_type = IMM_I; dec.imm = imm_i;
        dec.rd = in_instr[11:7];  dec.rs1 = in_instr[19:15]; dec.func3 = f_f3;
        bad = (f_f3 != 3'b000);
      end
      OP_FENCE, OP_SYSTEM: begin
        dec.inst_type = IT_SYS;   dec.imm_type = IMM_I; dec.imm = imm_i;
        dec.rd = in_instr[11:7];  dec.rs1 = in_instr[19:15]; dec.func3 = f_f3;
      end
      default: bad = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) bad = 1'b1;
    // Illegal entries keep pc/opcode but carry no decoded fields
    if (bad) begin
      dec          = '0;
      dec.pc       = in_pc;
      dec.opcode   = f_op;
      dec.imm_type = IMM_NONE;
      dec.illegal  = 1'b1;
    end
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = m_valid_q && out_ready;

  // Main/skid buffer next state; flush overrides any capture or drain
  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = in_fire;
        if (in_fire) s_d = dec;
      end else begin
        m_valid_d = in_fire;
        if (in_fire) m_d = dec;
      end
    end else if (in_fire) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
    in_ready_d = !s_valid_d;
  end

  // Buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q          <= '0;
      m_q.imm_type <= IMM_NONE;
      s_q          <= '0;
      s_q.imm_type <= IMM_NONE;
      m_valid_q    <= 1'b0;
      s_valid_q    <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      m_q          <= m_d;
      s_q          <= s_d;
      m_valid_q    <= m_valid_d;
      s_valid_q    <= s_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_pc    = m_q.pc;
  assign opcode    = m_q.opcode;
  assign rd        = m_q.rd;
  assign rs1       = m_q.rs1;
  assign rs2       = m_q.rs2;
  assign func3     = m_q.func3;
  assign func7     = m_q.func7;
  assign inst_type = m_q.inst_type;
  assign imm_type  = m_q.imm_type;
  assign imm       = m_q.imm;
  assign illegal   = m_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] decoded_cnt_q, decoded_cnt_d, illegal_cnt_q, illegal_cnt_d;

  // Count output transfers; flush does not suppress them
  always_comb begin
    decoded_cnt_d = decoded_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (out_fire) begin
      decoded_cnt_d = decoded_cnt_q + CNT_W'(1);
      if (m_q.illegal) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      decoded_cnt_q <= decoded_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign decoded_cnt = decoded_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides.
- Decodes all six base formats (R/I/S/B/U/J). Produces the fully sign-extended immediate and flags illegal encodings.
- A 2-entry skid buffer keeps full throughput under back-pressure. Sits between fetch and register-file read/control.

Parameters:
- XLEN, 32, width of the sign-extended immediate and of pc.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  pc of instruction.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  consumer accepts.
- out_pc  out  XLEN  pc passed through.
- opcode  out  7  instr[6:0].
- rd / rs1 / rs2  out  5 each  register fields; 0 when the format does not use them.
- func3  out  3  instr[14:12]; 0 for U/J.
- func7  out  7  instr[31:25]; valid only for R-type and shift-immediates, else 0.
- inst_type  out  4  0 illegal/none, 1 load, 2 store, 3 R-alu, 4 I-alu, 5 branch, 6 lui, 7 auipc, 8 jal, 9 jalr, 10 fence/system.
- imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 7 none.
- imm  out  XLEN  sign-extended immediate. B/J immediates have bit0=0; U is instr[31:12]<<12.
- illegal  out  1  decoded entry is an illegal encoding.

Behaviour:
- All outputs, buffer valids and counters reset to 0 asynchronously on rst; imm_type resets to 7.
- Latency: input accepted in cycle N appears on the outputs in cycle N+1.
- Storage: main register M drives the outputs; skid register S holds at most one entry.
- in_ready = !S.valid. This is a registered signal, with no combinational path from out_ready.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Decode happens combinationally on in_instr; the decoded fields are captured into M or S.
- Capture rules:
  - If M is empty, or M is being consumed this cycle, the new entry goes to M (or S moves to M first, then the new entry goes to S).
  - If M is full, M is not consumed, and the input transfers, the new entry goes to S.
  - When M drains and S is valid, S moves to M next cycle.
- Ordering is strictly FIFO. No bubble is inserted at full throughput (1 instruction per cycle when out_ready stays high).
- out_valid is held, and all out_* are held stable, until a transfer occurs.
- Flush clears M.valid and S.valid on the next edge. Flush has priority over a simultaneous input capture (that input is dropped) and over a simultaneous output transfer (the consumer must ignore it). in_ready is 1 the cycle after flush.
- Illegal detection (illegal=1, inst_type=0, imm_type=7, entry still passed downstream):
  - instr[1:0] != 2'b11.
  - Unknown opcode.
  - R-type func7 not in {0000000, 0100000}.
  - func7=0100000 with func3 not in {000, 101}.
  - SLLI with func7 != 0.
  - SRLI/SRAI with func7 not in {0000000, 0100000}.
  - Load func3 in {011, 110, 111}.
  - Store func3 > 010.
  - Branch func3 in {010, 011}.
  - jalr func3 != 0.
- Reset mid-operation: all in-flight entries are lost, with no partial outputs.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- Defined: adds outputs decoded_cnt (CNT_W) and illegal_cnt (CNT_W).
  - decoded_cnt increments on every output transfer.
  - illegal_cnt increments on output transfers with illegal=1.
  - Both wrap modulo 2^CNT_W, are not affected by flush, and are cleared by rst.
- Undefined: counters and ports are absent; all other behaviour is identical.

Test Plan:
- lw x5,8(x2) (0x00812283), out_ready=1 -> next cycle:
  - out_valid=1, inst_type=1, imm_type=0, rd=5, rs1=2, imm=8.
- sw x6,-4(x1) (0xFE60AE23) -> inst_type=2, imm_type=1, rs1=1, rs2=6, rd=0, imm=0xFFFFFFFC.
- beq x0,x0,-8 (0xFE000CE3) -> imm_type=2, imm=0xFFFFFFF8. Then jal x1,+2048 (0x001000EF) -> imm_type=4, imm=0x00000800, rd=1.
- Back-pressure: 4 back-to-back valid inputs with out_ready=0 ->
  - M and S fill, then in_ready=0.
  - Release out_ready -> all 4 emerge in order, with no loss or duplication.
- 0x0200A033 (R-type, func7=0000001) and 0x00000000 -> illegal=1, inst_type=0. With DECODE_PERF_CNT_EN: illegal_cnt=2, decoded_cnt=2.
- Flush while M and S are full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped input never appears.
